// File: rtl/freq_band_scheduler.sv
// ---------------------------------------------------------------------------
// freq_band_scheduler
//
// Time-shares one band-filter engine across seven frequency bands. Each
// accepted `ready` strobe latches one audio sample and the band-enable mask.
// The FSM then walks bands 0..6. Each enabled band is issued to the engine
// once, and the returned filter output becomes an 8-bit peak-hold level.
// Disabled bands are forced to level 0. At frame end the sample is copied to
// audio_out. A frame counter decays every level by one step each
// DECAY_SAMPLES frames.
//
// Optional feature (macro FBS_TIMEOUT_EN):
//   defined   - a band is abandoned after TIMEOUT_CYCLES cycles in WAIT
//               without eng_done. The sticky `timeout` flag is set and the
//               band's level is left untouched.
//   undefined - WAIT holds until eng_done; `timeout` is tied low.
//
// Ports:
//   clock, reset        posedge clock, async active-low reset
//   ready, audio_in     one-cycle sample strobe and signed 18-bit sample
//   controls            [6:0] band enable mask, [7] freeze (ignore ready)
//   eng_start/eng_band  engine request pulse and band index (held to UPDATE)
//   eng_sample          latched sample, held for the whole frame
//   eng_done/eng_result engine completion pulse and signed result
//   audio_out           frame-aligned copy of the sample
//   freq1..freq7        peak-hold levels of bands 0..6
//   busy                high outside IDLE
//   frame_done          one-cycle pulse after FINISH
//   overrun             sticky: ready seen while not IDLE
//   timeout             sticky: engine did not answer in time
// ---------------------------------------------------------------------------

// Per-band peak-hold level. Clear has priority over update. Decay happens only
// in FINISH, so the decay step always follows this frame's peak update.
module fbs_band_level (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       upd,
    input  logic       decay,
    input  logic [7:0] cand,
    output logic [7:0] level
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if (clr) begin
            level <= '0;
        end else if (upd) begin
            if (cand > level) level <= cand;
        end else if (decay && (level != 8'd0)) begin
            level <= level - 8'd1;
        end
    end
endmodule

module freq_band_scheduler #(
    parameter int DECAY_SAMPLES  = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [17:0] audio_in,
    input  logic [7:0]  controls,
    output logic        eng_start,
    output logic [2:0]  eng_band,
    output logic [17:0] eng_sample,
    input  logic        eng_done,
    input  logic [17:0] eng_result,
    output logic [17:0] audio_out,
    output logic [7:0]  freq1,
    output logic [7:0]  freq2,
    output logic [7:0]  freq3,
    output logic [7:0]  freq4,
    output logic [7:0]  freq5,
    output logic [7:0]  freq6,
    output logic [7:0]  freq7,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        timeout
);
    localparam int         NUM_BANDS = 7;
    localparam logic [2:0] LAST_BAND = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic        done;
        logic [17:0] result;
    } eng_rsp_t;

    state_t                        state, state_nxt;
    logic [2:0]                    band, band_nxt;
    logic [17:0]                   sample;
    logic [NUM_BANDS-1:0]          mask;
    logic [7:0]                    cand_q;
    logic [15:0]                   decay_cnt;
    logic                          decay_wrap;
    logic                          wait_expire;
    logic                          frame_go;
    eng_rsp_t                      rsp;

    logic [17:0]                   mag;
    logic [7:0]                    cand;
    logic                          unused_mag_lsb;

    logic [NUM_BANDS-1:0]          lvl_clr;
    logic [NUM_BANDS-1:0]          lvl_upd;
    logic [NUM_BANDS-1:0][7:0]     level;

    assign rsp      = '{done: eng_done, result: eng_result};
    assign frame_go = ready && !controls[7];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            band  <= '0;
        end else begin
            state <= state_nxt;
            band  <= band_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and engine request
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        band_nxt  = band;
        eng_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_go) begin
                    state_nxt = S_ISSUE;
                    band_nxt  = '0;
                end
            end
            S_ISSUE: begin
                if (mask[band]) begin
                    eng_start = 1'b1;
                    state_nxt = S_WAIT;
                end else if (band == LAST_BAND) begin
                    state_nxt = S_FINISH;
                end else begin
                    band_nxt = band + 3'd1;
                end
            end
            S_WAIT: begin
                if (rsp.done) begin
                    state_nxt = S_UPDATE;
                end else if (wait_expire) begin
                    // Abandoned band: skip UPDATE so the level stays as is.
                    if (band == LAST_BAND) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_ISSUE;
                        band_nxt  = band + 3'd1;
                    end
                end
            end
            S_UPDATE: begin
                if (band == LAST_BAND) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_ISSUE;
                    band_nxt  = band + 3'd1;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
                band_nxt  = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                band_nxt  = '0;
            end
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign eng_band   = band;
    assign eng_sample = sample;

    // ------------------------------------------------------------------
    // Result magnitude -> 8-bit candidate.
    // -131072 is the only value whose negation sets mag[17]; it saturates
    // to full scale, the same as 131071 would.
    // ------------------------------------------------------------------
    always_comb begin
        mag  = rsp.result[17] ? (~rsp.result + 18'd1) : rsp.result;
        cand = mag[17] ? 8'hFF : mag[16:9];
    end
    assign unused_mag_lsb = ^mag[8:0];

    assign decay_wrap = (decay_cnt == 16'(DECAY_SAMPLES - 1));

    // ------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample     <= '0;
            mask       <= '0;
            cand_q     <= '0;
            decay_cnt  <= '0;
            audio_out  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= (state == S_FINISH);
            // Any ready outside IDLE, including FINISH, drops the sample.
            if (ready && (state != S_IDLE)) overrun <= 1'b1;
            // The mask is latched once so mid-frame control edits wait a frame.
            if ((state == S_IDLE) && frame_go) begin
                sample <= audio_in;
                mask   <= controls[NUM_BANDS-1:0];
            end
            if ((state == S_WAIT) && rsp.done) cand_q <= cand;
            if (state == S_FINISH) begin
                audio_out <= sample;
                decay_cnt <= decay_wrap ? 16'd0 : decay_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-band level lanes
    // ------------------------------------------------------------------
    always_comb begin
        lvl_clr = '0;
        lvl_upd = '0;
        if ((state == S_ISSUE) && !mask[band]) lvl_clr[band] = 1'b1;
        if (state == S_UPDATE)                 lvl_upd[band] = 1'b1;
    end

    for (genvar i = 0; i < NUM_BANDS; i++) begin : g_band
        fbs_band_level u_lvl (
            .clock (clock),
            .reset (reset),
            .clr   (lvl_clr[i]),
            .upd   (lvl_upd[i]),
            .decay ((state == S_FINISH) && decay_wrap),
            .cand  (cand_q),
            .level (level[i])
        );
    end

    assign freq1 = level[0];
    assign freq2 = level[1];
    assign freq3 = level[2];
    assign freq4 = level[3];
    assign freq5 = level[4];
    assign freq6 = level[5];
    assign freq7 = level[6];

    // ------------------------------------------------------------------
    // Engine watchdog
    // ------------------------------------------------------------------
`ifdef FBS_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // The counter is cleared in ISSUE, so it always starts at 0 in the
    // first WAIT cycle. The band expires in its TIMEOUT_CYCLES-th WAIT cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
            if (wait_expire) timeout <= 1'b1;
        end
    end

    assign wait_expire = (state == S_WAIT) && !rsp.done &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign wait_expire        = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
`endif

endmodule

// File: tb/tb_freq_band_scheduler.sv
// ---------------------------------------------------------------------------
// tb_freq_band_scheduler
//
// Directed bench for freq_band_scheduler, built with DECAY_SAMPLES=4 and
// TIMEOUT_CYCLES=10. A behavioural engine answers L cycles after eng_start
// with a programmable value, or stays silent when muted. Frames run in one
// sequence: full mask, sparse mask with a saturating result, freeze, overrun,
// decay over eight frames, reset mid-WAIT, recovery, and an engine timeout
// when FBS_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_freq_band_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic [17:0] audio_in = '0;
    logic [7:0]  controls = '0;
    logic        eng_start;
    logic [2:0]  eng_band;
    logic [17:0] eng_sample;
    logic        eng_done = 1'b0;
    logic [17:0] eng_result = '0;
    logic [17:0] audio_out;
    logic [7:0]  freq1, freq2, freq3, freq4, freq5, freq6, freq7;
    logic        busy, frame_done, overrun, timeout;

    logic [6:0][7:0] lv;
    assign lv = {freq7, freq6, freq5, freq4, freq3, freq2, freq1};

    freq_band_scheduler #(
        .DECAY_SAMPLES  (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .audio_in   (audio_in),
        .controls   (controls),
        .eng_start  (eng_start),
        .eng_band   (eng_band),
        .eng_sample (eng_sample),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .audio_out  (audio_out),
        .freq1      (freq1),
        .freq2      (freq2),
        .freq3      (freq3),
        .freq4      (freq4),
        .freq5      (freq5),
        .freq6      (freq6),
        .freq7      (freq7),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    // Behavioural engine: a request seen in cycle c answers in cycle c+lat.
    int          eng_lat  = 3;
    logic [17:0] eng_val  = '0;
    bit          eng_mute = 1'b0;
    int          eng_cnt  = 0;

    always @(negedge clock) begin
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0 && !eng_mute) begin
                eng_done   = 1'b1;
                eng_result = eng_val;
            end
        end
        if (eng_start) eng_cnt = eng_lat;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic chk_lvls(input string tag, input logic [6:0][7:0] exp);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_freq%0d", tag, i + 1), {24'd0, lv[i]}, {24'd0, exp[i]});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_audio_out"}, {14'd0, audio_out}, 32'd0);
        chk({tag, "_eng_sample"}, {14'd0, eng_sample}, 32'd0);
        chk({tag, "_ctl"}, {25'd0, eng_start, eng_band, busy, frame_done, overrun}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk_lvls(tag, '0);
    endtask

    // Runs one frame from ready to frame_done. dup_at > 0 re-pulses ready
    // that many cycles after the first. ord records issued bands as octal
    // digits (band+1).
    task automatic run_frame(input logic [17:0] smp, input logic [7:0] ctl, input int dup_at,
                             output int cyc, output int starts, output int ord);
        cyc = 0; starts = 0; ord = 0;
        @(negedge clock);
        audio_in = smp; controls = ctl; ready = 1'b1;
        while (cyc < 400) begin
            @(negedge clock);
            cyc++;
            ready = (cyc == dup_at);
            if (cyc == dup_at) audio_in = 18'h15555;
            if (eng_start) begin
                starts++;
                ord = ord * 8 + int'(eng_band) + 1;
            end
            if (frame_done) break;
        end
        ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, st, ord, s, b;

        // Reset state
        repeat (3) @(negedge clock);
        chk_zero("rst");
        reset = 1'b1;
        @(negedge clock);
        chk_zero("rst_rel");

        // Frame 1: all bands, L=3, result 4096 -> level 8 everywhere
        eng_lat = 3; eng_val = 18'h01000;
        run_frame(18'h12345, 8'h7F, 0, cyc, st, ord);
        chk("f1_cycles", cyc, 37);
        chk("f1_starts", st, 7);
        chk("f1_order", ord, 'o1234567);
        chk("f1_audio_out", {14'd0, audio_out}, 32'h12345);
        chk_lvls("f1", {8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8});
        chk("f1_busy", {31'd0, busy}, 0);

        // Frame 2: bands 0 and 2 only, result -131072 saturates to 255
        eng_val = 18'h20000;
        run_frame(18'h3FFFF, 8'h05, 0, cyc, st, ord);
        chk("f2_cycles", cyc, 17);
        chk("f2_starts", st, 2);
        chk("f2_order", ord, 'o13);
        chk("f2_audio_out", {14'd0, audio_out}, 32'h3FFFF);
        chk_lvls("f2", {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255});

        // Freeze: ready pulses are ignored entirely
        s = 0; b = 0;
        controls = 8'h85;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            ready = (k % 5 == 0);
            audio_in = 18'h00777;
            if (eng_start) s++;
            if (busy) b++;
        end
        ready = 1'b0;
        chk("frz_starts", s, 0);
        chk("frz_busy_cycles", b, 0);
        chk("frz_overrun", {31'd0, overrun}, 0);
        chk("frz_eng_sample", {14'd0, eng_sample}, 32'h3FFFF);
        chk_lvls("frz", {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255});

        // Frame 3: second ready while busy -> overrun, sample dropped
        eng_val = 18'h01000;
        run_frame(18'h00ABC, 8'h7F, 5, cyc, st, ord);
        chk("f3_cycles", cyc, 37);
        chk("f3_starts", st, 7);
        chk("f3_overrun", {31'd0, overrun}, 1);
        chk("f3_audio_out", {14'd0, audio_out}, 32'h00ABC);
        chk_lvls("f3", {8'd8, 8'd8, 8'd8, 8'd8, 8'd255, 8'd8, 8'd255});
        s = 0; b = 0;
        repeat (10) begin
            @(negedge clock);
            if (eng_start) s++;
            if (busy) b++;
        end
        chk("f3_idle_starts", s, 0);
        chk("f3_idle_busy", b, 0);
        chk("f3_idle_audio_out", {14'd0, audio_out}, 32'h00ABC);

        // Frame 4: band 1 peaks at 10, then the 4th-frame decay makes it 9
        eng_val = 18'h01400;
        run_frame(18'h00004, 8'h02, 0, cyc, st, ord);
        chk("f4_cycles", cyc, 13);
        chk_lvls("f4", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0});

        // Frames 5..8: bands 0,1 see result 0; band 1 decays on frame 8 only
        eng_val = 18'h00000;
        for (int f = 5; f <= 8; f++) begin
            run_frame(18'(f), 8'h03, 0, cyc, st, ord);
            chk($sformatf("f%0d_cycles", f), cyc, 17);
            chk($sformatf("f%0d_freq2", f), {24'd0, freq2}, (f == 8) ? 32'd8 : 32'd9);
            chk($sformatf("f%0d_freq1", f), {24'd0, freq1}, 32'd0);
        end

        // Reset asserted in WAIT: everything clears at once; late eng_done ignored
        eng_val = 18'h01000;
        @(negedge clock);
        audio_in = 18'h01111; controls = 8'h7F; ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        chk("mid_busy", {31'd0, busy}, 1);
        #2 reset = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clock);
        reset = 1'b1;
        s = 0; b = 0;
        repeat (8) begin
            @(negedge clock);
            if (eng_start) s++;
            if (busy || frame_done) b++;
        end
        chk("late_starts", s, 0);
        chk("late_busy", b, 0);
        chk_lvls("late", '0);

        // Recovery frame after reset
        run_frame(18'h02222, 8'h7F, 0, cyc, st, ord);
        chk("rec_cycles", cyc, 37);
        chk("rec_audio_out", {14'd0, audio_out}, 32'h02222);
        chk("rec_overrun", {31'd0, overrun}, 0);
        chk("rec_timeout", {31'd0, timeout}, 0);
        chk_lvls("rec", {8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8});

`ifdef FBS_TIMEOUT_EN
        // Silent engine: each band gives up after 10 WAIT cycles
        eng_mute = 1'b1;
        run_frame(18'h03333, 8'h7F, 0, cyc, st, ord);
        eng_mute = 1'b0;
        chk("to_cycles", cyc, 79);
        chk("to_starts", st, 7);
        chk("to_timeout", {31'd0, timeout}, 1);
        chk("to_audio_out", {14'd0, audio_out}, 32'h03333);
        chk_lvls("to", {8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/freq_band_scheduler.md
Name: freq_band_scheduler

Overview:
- Per-sample controller that time-shares one band-filter engine across seven frequency bands.
- On each `ready` strobe it latches the sample, then issues the engine once per enabled band and converts each result to an 8-bit peak-hold level with decay.
- Drives the seven band-level outputs plus a frame-aligned copy of the audio.
- Sits between the audio codec sample path and the display/visualiser logic.

Parameters:
- DECAY_SAMPLES, 64, completed frames between level decrements; legal range 1..65535.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a band is abandoned; used only with FBS_TIMEOUT_EN; legal range 1..65535.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- ready  in  1  one-cycle sample strobe.
- audio_in  in  18  signed sample, valid when ready=1.
- controls  in  8  [6:0] band enable mask (bit i enables band i); [7] freeze.
- eng_start  out  1  one-cycle engine request.
- eng_band  out  3  band index 0..6; held stable from ISSUE until the UPDATE decision.
- eng_sample  out  18  latched sample; held for the whole frame.
- eng_done  in  1  one-cycle engine completion.
- eng_result  in  18  signed filter output, valid when eng_done=1.
- audio_out  out  18  latched sample, updated at frame end.
- freq1..freq7  out  8 each  levels for bands 0..6.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky; a ready arrived while busy.
- timeout  out  1  sticky engine-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; band index 0; decay counter 0; latched sample and latched mask 0.
- IDLE:
  - ready=1 and controls[7]=0: latch audio_in into eng_sample, latch controls[6:0] as the frame mask, set band=0, go to ISSUE.
  - ready=1 and controls[7]=1: ignored; no state change, no overrun.
- ISSUE:
  - Current band disabled in the latched mask: set its level to 0. If band=6 go to FINISH, else band+1 and stay in ISSUE. Cost is 1 cycle per disabled band.
  - Current band enabled: assert eng_start for 1 cycle, go to WAIT.
- WAIT:
  - Hold until eng_done=1, then capture eng_result and go to UPDATE.
  - eng_done while not in WAIT is ignored.
- UPDATE:
  - mag = |eng_result|, with -131072 saturated to 131071.
  - cand = mag[16:9].
  - level[band] = max(level[band], cand).
  - If band=6 go to FINISH, else band+1 and go to ISSUE.
- FINISH (1 cycle):
  - audio_out <= latched sample.
  - Decay counter increments. When it reaches DECAY_SAMPLES-1 it wraps to 0 and every level decrements by 1, saturating at 0. The decrement is applied after this frame's peak updates.
  - Pulse frame_done; go to IDLE.
- Overrun: ready=1 in any state other than IDLE sets overrun, and the sample is dropped. A ready in the same cycle as FINISH is also an overrun. overrun stays set until reset.
- Mid-frame controls changes do not affect the current frame, because the mask is latched at frame start.
- Latency:
  - All bands enabled, engine latency L cycles from eng_start to eng_done: frame = 7*(L+2)+2 cycles from ready to frame_done.
  - All bands disabled: 9 cycles (IDLE→ISSUE plus 7 ISSUE cycles, then FINISH).
- Mask equal to 0: full frame runs, all levels forced to 0, frame_done still pulses.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. A late eng_done after reset is ignored.

Optional Feature:
- Macro: FBS_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - If the count reaches TIMEOUT_CYCLES with no eng_done, set timeout (sticky). The band's level is unchanged; proceed as if UPDATE completed, i.e. next band or FINISH.
- Undefined:
  - WAIT holds indefinitely.
  - timeout is tied to 0, and no counter logic is built.

Test Plan:
- Reset, mask=0x7F, engine L=3 returning 0x01000 (4096) for all bands → eng_start count=7; bands issued in order 0..6; all freqN=8; frame_done at cycle 37 after ready; audio_out=sample.
- controls=0x05, result -131072 → freq1=freq3=255, all other levels 0; only bands 0 and 2 issued.
- ready pulsed again 5 cycles after the first, while busy → overrun=1; second sample never appears on audio_out; only 7 eng_start pulses total.
- DECAY_SAMPLES=4, level 10, subsequent results 0 → level reads 9 after frame 4 and 8 after frame 8; a level of 0 stays at 0.
- controls[7]=1 with ready pulses → no eng_start, busy stays 0, overrun stays 0, levels held.
- FBS_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, engine never responds → timeout=1 after 10 WAIT cycles per band; frame_done still pulses; levels unchanged. A separate run asserts reset mid-WAIT → all outputs 0 immediately.
